fetch_if_stage: RTL and testbench

- Instruction-fetch stage, directly upstream of the decode stage.
- Owns the PC and issues one-outstanding-request fetches to instruction memory over a req/ack handshake.
- Drives the IF/ID pipeline register: instruction word and PC+4, consumed by decode for register read and branch target.
- Honours the decode stage's hold_pc/hold_if stall and its br/pc_branch redirect.

---
 rtl/fetch_if_stage_if.sv | 21 ++
 rtl/fetch_if_stage.sv | 166 ++++++++++++++++
 tb/tb_fetch_if_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if_stage_if.sv
// rtl/fetch_if_stage_if.sv - instruction memory req/ack bus between fetch stage and imem
interface fetch_if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_if_stage.sv
// rtl/fetch_if_stage.sv - instruction fetch stage with IF/ID register; optional FETCH_STALL_CNT_EN stall counter
module fetch_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold_pc,
    input  logic               hold_if,
    input  logic               br,
    input  logic [31:0]        pc_branch,
    fetch_if_stage_if.master   imem,
    output logic [31:0]        inst_out,
    output logic [31:0]        pc_out,
    output logic               inst_valid
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    logic        hold;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign hold     = hold_pc | hold_if;
    assign target   = {pc_branch[31:2], 2'b00};
    assign pc_plus4 = pc_q + 32'd4;

    // The request is a pure function of state; nothing is requested while in reset
    // or while a fetched word waits in the skid buffer.
    assign imem.imem_req  = ~rst & (state_q != S_HOLD);
    assign imem.imem_addr = req_addr_q;

    assign inst_out   = inst_q;
    assign pc_out     = pc_out_q;
    assign inst_valid = valid_q;

    // Next-state: redirect beats stall beats normal flow in every state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        skid_d     = skid_q;
        skid_pc_d  = skid_pc_q;
        inst_d     = inst_q;
        pc_out_d   = pc_out_q;
        valid_d    = valid_q;
        unique case (state_q)
            S_REQ: begin
                if (br) begin
                    pc_d    = target;
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    if (imem.imem_ack) begin
                        req_addr_d = target;
                    end else begin
                        // Old address must stay on the bus until its ack returns.
                        state_d = S_DROP;
                    end
                end else if (hold) begin
                    if (imem.imem_ack) begin
                        skid_d    = imem.imem_rdata;
                        skid_pc_d = pc_plus4;
                        state_d   = S_HOLD;
                    end
                end else if (imem.imem_ack) begin
                    inst_d     = imem.imem_rdata;
                    pc_out_d   = pc_plus4;
                    valid_d    = 1'b1;
                    pc_d       = pc_plus4;
                    req_addr_d = pc_plus4;
                end else begin
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (br) begin
                    pc_d       = target;
                    req_addr_d = target;
                    inst_d     = NOP_INST;
                    valid_d    = 1'b0;
                    state_d    = S_REQ;
                end else if (!hold) begin
                    inst_d     = skid_q;
                    pc_out_d   = skid_pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_plus4;
                    req_addr_d = pc_plus4;
                    state_d    = S_REQ;
                end
            end
            S_DROP: begin
                if (br) begin
                    pc_d = target;
                end
                if (imem.imem_ack) begin
                    req_addr_d = br ? target : pc_q;
                    state_d    = S_REQ;
                end
                if (br || !hold) begin
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State and IF/ID register, asynchronously reset to the reset vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            skid_q     <= 32'd0;
            skid_pc_q  <= 32'd0;
            inst_q     <= NOP_INST;
            pc_out_q   <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            skid_q     <= skid_d;
            skid_pc_q  <= skid_pc_d;
            inst_q     <= inst_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    assign stall_cnt = stall_cnt_q;

    // Counts every cycle that leaves decode without a fresh instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else if (hold || !valid_d) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_if_stage.sv
// tb/tb_fetch_if_stage.sv - scoreboard bench for fetch_if_stage against a program-order fetch model
module tb_fetch_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold_pc, hold_if, br;
    logic [31:0] pc_branch;
    logic [31:0] inst_out, pc_out;
    logic        inst_valid;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    fetch_if_stage_if bus();

    fetch_if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk        (clk),
        .rst        (rst),
        .hold_pc    (hold_pc),
        .hold_if    (hold_if),
        .br         (br),
        .pc_branch  (pc_branch),
        .imem       (bus),
        .inst_out   (inst_out),
        .pc_out     (pc_out),
        .inst_valid (inst_valid)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h8C22_0004;
            32'h0000_0004: mem_word = 32'h0043_2020;
            default:       mem_word = (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
        endcase
    endfunction

    // Scoreboard: the program-order stream decode must see from the last redirect.
    typedef struct { logic [31:0] pc4; logic [31:0] inst; } exp_t;
    exp_t exp_q[$];
    exp_t pres_log[$];
    logic [31:0] cap_log[$];

    task automatic sb_extend();
        logic [31:0] p;
        while (exp_q.size() < 48) begin
            p = exp_q[exp_q.size()-1].pc4;
            exp_q.push_back('{pc4: p + 32'd4, inst: mem_word(p)});
        end
    endtask

    task automatic sb_restart(input logic [31:0] start);
        logic [31:0] s;
        s = {start[31:2], 2'b00};
        exp_q.delete();
        exp_q.push_back('{pc4: s + 32'd4, inst: mem_word(s)});
        sb_extend();
    endtask

    int rst_cnt = 0;
    always @(posedge rst) rst_cnt++;

    // Memory model: one request at a time, ack after 'lat' cycles.
    int          lat = 1;
    logic        mem_busy = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_cap = 32'd0;
    int          mem_rst_seen = 0;

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #3;
            if (rst || rst_cnt != mem_rst_seen) begin
                mem_rst_seen   = rst_cnt;
                mem_busy       = 1'b0;
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = 32'd0;
            end else begin
                if (bus.imem_ack) begin
                    bus.imem_ack = 1'b0;
                    mem_busy     = 1'b0;
                end
                if (mem_busy) begin
                    chk("req_held", {31'd0, bus.imem_req}, 32'd1);
                    chk("addr_stable", bus.imem_addr, mem_cap);
                    mem_wait--;
                    if (mem_wait == 0) begin
                        bus.imem_ack   = 1'b1;
                        bus.imem_rdata = mem_word(mem_cap);
                    end
                end else if (bus.imem_req) begin
                    chk("addr_aligned", {30'd0, bus.imem_addr[1:0]}, 32'd0);
                    mem_cap  = bus.imem_addr;
                    mem_busy = 1'b1;
                    mem_wait = lat;
                    cap_log.push_back(bus.imem_addr);
                end
            end
        end
    end

    // Monitor: classifies each clock edge from the inputs that were applied to it.
    logic [31:0] prev_inst = NOP_INST, prev_pc = 32'd0;
    logic        prev_valid = 1'b0;
    int          mon_rst_seen = 0;
    logic [31:0] model_stall = 32'd0;
    int          presented = 0;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                chk("rst_inst", inst_out, NOP_INST);
                chk("rst_pc", pc_out, 32'd0);
                chk("rst_valid", {31'd0, inst_valid}, 32'd0);
                mon_rst_seen = rst_cnt;
                model_stall  = 32'd0;
            end else begin
                if (rst_cnt != mon_rst_seen) begin
                    mon_rst_seen = rst_cnt;
                    prev_inst    = NOP_INST;
                    prev_pc      = 32'd0;
                    prev_valid   = 1'b0;
                    model_stall  = 32'd0;
                end
                if (br) begin
                    chk("br_valid", {31'd0, inst_valid}, 32'd0);
                    chk("br_inst", inst_out, NOP_INST);
                    chk("br_pc", pc_out, prev_pc);
                end else if (hold_pc || hold_if) begin
                    chk("hold_inst", inst_out, prev_inst);
                    chk("hold_pc", pc_out, prev_pc);
                    chk("hold_valid", {31'd0, inst_valid}, {31'd0, prev_valid});
                end else if (inst_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_empty actual=pc_out %h expected=no instruction", pc_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc_out", pc_out, e.pc4);
                        chk("sb_inst", inst_out, e.inst);
                        pres_log.push_back('{pc4: pc_out, inst: inst_out});
                        presented++;
                        sb_extend();
                    end
                end else begin
                    chk("bub_inst", inst_out, NOP_INST);
                    chk("bub_pc", pc_out, prev_pc);
                end
                if (hold_pc || hold_if || !inst_valid) model_stall = model_stall + 32'd1;
`ifdef FETCH_STALL_CNT_EN
                chk("stall_cnt", stall_cnt, model_stall);
`endif
            end
            prev_inst  = inst_out;
            prev_pc    = pc_out;
            prev_valid = inst_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #4;
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (!bus.imem_ack && n < 50) begin
            tick();
            n++;
        end
        if (!bus.imem_ack) begin
            checks++;
            failures++;
            $display("FAIL wait_ack actual=timeout expected=ack within 50 cycles");
        end
    endtask

    task automatic chk_cap(input string name, input int idx, input logic [31:0] exp);
        if (cap_log.size() <= idx) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no request expected=%h", name, exp);
        end else begin
            chk(name, cap_log[idx], exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        logic [31:0] held;
        logic [31:0] t;
        logic        found;
        rst = 1'b1; hold_pc = 1'b0; hold_if = 1'b0; br = 1'b0; pc_branch = 32'd0;
        sb_restart(RESET_PC);
        repeat (3) tick();
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        rst = 1'b0;

        // Sequential fetch
        repeat (8) tick();
        chk_cap("seq_addr0", 0, 32'h0);
        chk_cap("seq_addr1", 1, 32'h4);
        chk_cap("seq_addr2", 2, 32'h8);
        if (pres_log.size() < 2) begin
            checks++; failures++;
            $display("FAIL seq_count actual=%0d expected=2", pres_log.size());
        end else begin
            chk("seq_inst0", pres_log[0].inst, 32'h8C22_0004);
            chk("seq_pc0", pres_log[0].pc4, 32'h4);
            chk("seq_inst1", pres_log[1].inst, 32'h0043_2020);
            chk("seq_pc1", pres_log[1].pc4, 32'h8);
        end

        // Load-use hold across an ack
        wait_ack();
        held = mem_cap;
        base = cap_log.size();
        hold_pc = 1'b1; hold_if = 1'b1;
        tick();
        chk("hold_req_low", {31'd0, bus.imem_req}, 32'd0);
        tick();
        hold_pc = 1'b0; hold_if = 1'b0;
        repeat (3) tick();
        chk_cap("hold_next_addr", base, held + 32'd4);

        // Branch in the ack cycle
        wait_ack();
        base = cap_log.size();
        br = 1'b1; pc_branch = 32'h0000_0040; sb_restart(32'h40);
        tick();
        br = 1'b0;
        chk("br_bubble", {31'd0, inst_valid}, 32'd0);
        repeat (2) tick();
        chk_cap("br_addr", base, 32'h40);

        // Branch while a slow fetch is in flight
        lat = 3;
        n = 0;
        while (!(mem_busy && mem_wait == 3) && n < 50) begin tick(); n++; end
        tick();
        base = cap_log.size();
        br = 1'b1; pc_branch = 32'h0000_0080; sb_restart(32'h80);
        tick();
        br = 1'b0;
        repeat (10) tick();
        chk_cap("inflight_addr", base, 32'h80);
        lat = 1;

        // Asynchronous reset pulse while parked in S_HOLD
        wait_ack();
        hold_pc = 1'b1;
        tick();
        chk("shold_req", {31'd0, bus.imem_req}, 32'd0);
        base = cap_log.size();
        #2 rst = 1'b1;
        #1;
        chk("arst_inst", inst_out, NOP_INST);
        chk("arst_valid", {31'd0, inst_valid}, 32'd0);
        chk("arst_pc", pc_out, 32'd0);
        chk("arst_req", {31'd0, bus.imem_req}, 32'd0);
        #1 rst = 1'b0;
        hold_pc = 1'b0;
        sb_restart(RESET_PC);
        repeat (4) tick();
        chk_cap("arst_addr", base, RESET_PC);

        // Misaligned target
        wait_ack();
        base = cap_log.size();
        br = 1'b1; pc_branch = 32'h0000_0023; sb_restart(32'h20);
        tick();
        br = 1'b0;
        repeat (2) tick();
        chk_cap("misalign_addr", base, 32'h20);

        // Wrap past the top of the address space
        wait_ack();
        base = cap_log.size();
        br = 1'b1; pc_branch = 32'hFFFF_FFF8; sb_restart(32'hFFFF_FFF8);
        tick();
        br = 1'b0;
        repeat (12) tick();
        found = 1'b0;
        for (int i = base; i + 1 < cap_log.size(); i++)
            if (cap_log[i] == 32'hFFFF_FFFC && cap_log[i+1] == 32'h0) found = 1'b1;
        chk("wrap_addr", {31'd0, found}, 32'd1);
        found = 1'b0;
        foreach (pres_log[i])
            if (pres_log[i].pc4 == 32'h0 && pres_log[i].inst == mem_word(32'hFFFF_FFFC)) found = 1'b1;
        chk("wrap_pc_out", {31'd0, found}, 32'd1);

        // Randomized traffic
        n = presented;
        for (int c = 0; c < 3000; c++) begin
            lat = $urandom_range(1, 3);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1; br = 1'b0; hold_pc = 1'b0; hold_if = 1'b0;
                sb_restart(RESET_PC);
                tick();
                rst = 1'b0;
            end else begin
                br = ($urandom_range(0, 11) == 0);
                if (br) begin
                    if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFE0 + $urandom_range(0, 31);
                    else t = $urandom_range(0, 4095);
                    pc_branch = t;
                    sb_restart(t);
                end
                hold_pc = ($urandom_range(0, 9) == 0);
                hold_if = ($urandom_range(0, 9) == 0);
                tick();
            end
        end
        br = 1'b0; hold_pc = 1'b0; hold_if = 1'b0;
        repeat (4) tick();
        checks++;
        if (presented - n < 200) begin
            failures++;
            $display("FAIL throughput actual=%0d expected=at least 200", presented - n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
